// File: rtl/cipher_pkg.sv
// Shared types and default sizing for the stream cipher controller.
package cipher_pkg;
    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KEY,
        ST_INIT,
        ST_WARMUP,
        ST_READY
    } state_t;

    localparam int KEY_BYTES_DEF     = 16;
    localparam int WARMUP_CYCLES_DEF = 8;
endpackage

// File: rtl/cipher_out_reg.sv
// One-entry valid/ready holding register for ciphertext bytes.
module cipher_out_reg
    import cipher_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       space_o
);
    byte_t data_q;
    logic  valid_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // A draining entry frees the slot in the same cycle, so accepts run back-to-back.
    assign space_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/stream_cipher_ctrl.sv
// Key load / keystream warmup / XOR sequencing for a byte stream cipher.
// Optional CIPHER_CTRL_ERR_EN adds err_pulse/err_count for dropped data bytes.
module stream_cipher_ctrl
    import cipher_pkg::*;
#(
    parameter int KEY_BYTES     = KEY_BYTES_DEF,
    parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [7:0]                   in_byte,
    input  logic                         in_is_key,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [7:0]                   key_byte,
    output logic                         key_we,
    output logic [$clog2(KEY_BYTES)-1:0] key_idx,
    output logic                         ks_init,
    output logic                         ks_step,
    input  logic [7:0]                   ks_byte,
    output logic [7:0]                   ct_byte,
    output logic                         ct_valid,
    input  logic                         ct_ready,
    output logic                         key_loaded
`ifdef CIPHER_CTRL_ERR_EN
    ,
    output logic                         err_pulse,
    output logic [7:0]                   err_count
`endif
);
    localparam int IDXW = $clog2(KEY_BYTES);

    state_t          state_q, state_d;
    logic [IDXW-1:0] count_q, count_d;
    logic [7:0]      warm_q, warm_d;
    logic            out_space;
    logic            ct_load;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            warm_q  <= warm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        warm_d     = warm_q;
        in_ready   = 1'b0;
        key_byte   = in_byte;
        key_we     = 1'b0;
        key_idx    = '0;
        ks_init    = 1'b0;
        ks_step    = 1'b0;
        ct_load    = 1'b0;
        key_loaded = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_is_key) begin
                    key_we  = 1'b1;
                    count_d = IDXW'(1);
                    state_d = ST_LOAD_KEY;
                end
            end
            ST_LOAD_KEY: begin
                in_ready = 1'b1;
                key_idx  = count_q;
                if (in_valid && in_is_key) begin
                    key_we = 1'b1;
                    if (count_q == IDXW'(KEY_BYTES - 1)) begin
                        count_d = '0;
                        state_d = ST_INIT;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_INIT: begin
                ks_init = 1'b1;
                warm_d  = '0;
                state_d = ST_WARMUP;
            end
            ST_WARMUP: begin
                ks_step = 1'b1;
                warm_d  = warm_q + 8'd1;
                if (warm_q == 8'(WARMUP_CYCLES - 1))
                    state_d = ST_READY;
            end
            ST_READY: begin
                key_loaded = 1'b1;
                // Key bytes never wait on the output slot; a rekey leaves the pending byte alone.
                in_ready   = in_is_key || out_space;
                if (in_valid && in_is_key) begin
                    key_we  = 1'b1;
                    count_d = IDXW'(1);
                    state_d = ST_LOAD_KEY;
                end else if (in_valid && out_space) begin
                    ks_step = 1'b1;
                    ct_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    cipher_out_reg u_out_reg (
        .clk     (clk),
        .nrst    (nrst),
        .load_i  (ct_load),
        .data_i  (in_byte ^ ks_byte),
        .ready_i (ct_ready),
        .valid_o (ct_valid),
        .data_o  (ct_byte),
        .space_o (out_space)
    );

`ifdef CIPHER_CTRL_ERR_EN
    logic       drop;
    logic [7:0] err_count_q;

    assign drop = in_valid && !in_is_key && (state_q == ST_IDLE || state_q == ST_LOAD_KEY);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            err_count_q <= '0;
        else if (drop && err_count_q != 8'hFF)
            err_count_q <= err_count_q + 8'd1;
    end

    assign err_pulse = drop;
    assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// Self-checking bench for stream_cipher_ctrl (KEY_BYTES=4, WARMUP_CYCLES=8).
module tb_stream_cipher_ctrl;
    localparam int KB = 4;
    localparam int WC = 8;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] in_byte, ks_byte, key_byte, ct_byte;
    logic       in_is_key, in_valid, in_ready, key_we, ks_init, ks_step;
    logic       ct_valid, ct_ready, key_loaded;
    logic [1:0] key_idx;
`ifdef CIPHER_CTRL_ERR_EN
    logic       err_pulse;
    logic [7:0] err_count;
`endif

    stream_cipher_ctrl #(.KEY_BYTES(KB), .WARMUP_CYCLES(WC)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_byte    (in_byte),
        .in_is_key  (in_is_key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key_byte   (key_byte),
        .key_we     (key_we),
        .key_idx    (key_idx),
        .ks_init    (ks_init),
        .ks_step    (ks_step),
        .ks_byte    (ks_byte),
        .ct_byte    (ct_byte),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .key_loaded (key_loaded)
`ifdef CIPHER_CTRL_ERR_EN
        ,
        .err_pulse  (err_pulse),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       k;
        logic [7:0] b;
        logic [7:0] exp;  // {in_ready, key_we, key_idx[1:0], ks_init, ks_step, key_loaded, ct_valid}
    } vec_t;

    vec_t       tbl[14];
    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] obs();
        return {in_ready, key_we, key_idx, ks_init, ks_step, key_loaded, ct_valid};
    endfunction

    function automatic vec_t mk(input logic v, input logic k, input logic [7:0] b, input logic [7:0] e);
        vec_t r;
        r.v = v; r.k = k; r.b = b; r.exp = e;
        return r;
    endfunction

    // Inputs change 1 unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input logic v, input logic k, input logic [7:0] b, input logic [7:0] ks,
                        input logic ctr, input logic acc);
        @(posedge clk); #1;
        in_valid = v; in_is_key = k; in_byte = b; ks_byte = ks; ct_ready = ctr;
        if (acc) sb.push_back(b ^ ks);
        @(negedge clk);
    endtask

    task automatic load_from(input int s, input logic ctv, input int nw);
        for (int i = s; i < KB; i++) begin
            step(1, 1, 8'hB0 + 8'(i), 8'h00, 0, 0);
            check("ld_we_idx", {key_we, key_idx}, {1'b1, 2'(i)});
        end
        step(0, 0, 0, 0, 0, 0);
        check("ld_init", {ks_init, ks_step, in_ready}, 3'b100);
        for (int w = 0; w < nw; w++) begin
            step(0, 0, 0, 0, 0, 0);
            check("ld_warm", {ks_init, ks_step, in_ready, key_loaded}, 4'b0100);
        end
        if (nw == WC) begin
            step(0, 0, 0, 0, 0, 0);
            check("ld_ready", {key_loaded, ks_step, ct_valid}, {2'b10, ctv});
        end
    endtask

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (nrst) begin
            check("init_step_excl", ks_init && ks_step, 0);
            if (ct_valid && ct_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL ct_unexpected: got %02h expected no output", ct_byte);
                end else begin
                    e = sb.pop_front();
                    check("ct_byte", ct_byte, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nrst = 0; in_valid = 0; in_is_key = 0; in_byte = 0; ks_byte = 0; ct_ready = 0;
        tbl[0]  = mk(1, 1, 8'h11, 8'b1100_0000);
        tbl[1]  = mk(1, 1, 8'h22, 8'b1101_0000);
        tbl[2]  = mk(1, 1, 8'h33, 8'b1110_0000);
        tbl[3]  = mk(1, 1, 8'h44, 8'b1111_0000);
        tbl[4]  = mk(0, 0, 8'h00, 8'b0000_1000);
        for (int i = 5; i < 13; i++) tbl[i] = mk(0, 0, 8'h00, 8'b0000_0100);
        tbl[13] = mk(0, 0, 8'h00, 8'b1000_0010);

        repeat (3) @(negedge clk);
        check("rst_obs", obs(), 8'b1000_0000);
        check("rst_ct_byte", ct_byte, 0);
`ifdef CIPHER_CTRL_ERR_EN
        check("rst_err_count", err_count, 0);
`endif
        nrst = 1;

        // initial key load through warmup
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].k, tbl[i].b, 8'h00, 0, 0);
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
            if (tbl[i].exp[6]) check($sformatf("vec%0d_key_byte", i), key_byte, tbl[i].b);
        end

        // single XOR, 1-cycle latency
        step(1, 0, 8'h3C, 8'hA5, 1, 1);
        check("a_accept", {in_ready, ks_step, ks_init}, 3'b110);
        step(0, 0, 0, 0, 1, 0);
        check("a_ct_valid", ct_valid, 1);
        check("a_ct_byte", ct_byte, 8'h99);
        step(0, 0, 0, 0, 1, 0);
        check("a_clear", ct_valid, 0);

        // backpressure then back-to-back drain+accept
        step(1, 0, 8'h10, 8'h01, 0, 1);
        check("b_acc1", {in_ready, ks_step}, 2'b11);
        step(1, 0, 8'h20, 8'h02, 0, 0);
        check("b_hold", {in_ready, ks_step, ct_valid}, 3'b001);
        check("b_hold_byte", ct_byte, 8'h11);
        step(1, 0, 8'h20, 8'h02, 0, 0);
        check("b_hold2", {in_ready, ks_step, ct_valid}, 3'b001);
        step(1, 0, 8'h20, 8'h02, 1, 1);
        check("b_b2b", {in_ready, ks_step, ct_valid}, 3'b111);
        step(0, 0, 0, 0, 1, 0);
        check("b_second", ct_valid, 1);
        step(0, 0, 0, 0, 1, 0);
        check("b_empty", ct_valid, 0);

        // rekey with a pending ciphertext byte
        step(1, 0, 8'h77, 8'h0F, 0, 1);
        check("c_acc", {in_ready, ks_step}, 2'b11);
        step(1, 1, 8'hAA, 8'h00, 0, 0);
        check("c_rekey", obs(), 8'b1100_0011);
        step(0, 0, 0, 0, 0, 0);
        check("c_unloaded", {key_loaded, ct_valid, key_we}, 3'b010);
        check("c_pending", ct_byte, 8'h78);
        load_from(1, 1'b1, WC);
        check("c_survive", ct_byte, 8'h78);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("c_drained", ct_valid, 0);

        // data drop mid-load leaves the count alone, then reset in warmup cycle 3
        step(1, 1, 8'hC0, 8'h00, 0, 0);
        check("d_rekey", {key_we, key_idx}, 3'b100);
        step(1, 0, 8'h55, 8'h00, 0, 0);
        check("d_drop", {in_ready, key_we, ks_step}, 3'b100);
`ifdef CIPHER_CTRL_ERR_EN
        check("d_err_pulse", err_pulse, 1);
`endif
        step(0, 0, 0, 0, 0, 0);
        check("d_no_out", ct_valid, 0);
`ifdef CIPHER_CTRL_ERR_EN
        check("d_err_count", err_count, 1);
`endif
        load_from(1, 1'b0, 2);
        step(0, 0, 0, 0, 0, 0);
        check("e_warm3", ks_step, 1);
        nrst = 0;
        #1;
        check("e_rst_obs", obs(), 8'b1000_0000);
        check("e_rst_ct_byte", ct_byte, 0);
`ifdef CIPHER_CTRL_ERR_EN
        check("e_rst_err", err_count, 0);
`endif
        #2 nrst = 1;

        // drop in IDLE
        step(1, 0, 8'h55, 8'h00, 1, 0);
        check("f_drop", {in_ready, ks_step, key_we}, 3'b100);
`ifdef CIPHER_CTRL_ERR_EN
        check("f_err_pulse", err_pulse, 1);
`endif
        step(0, 0, 0, 0, 1, 0);
        check("f_no_out", ct_valid, 0);
`ifdef CIPHER_CTRL_ERR_EN
        check("f_err_count", err_count, 1);
        repeat (300) step(1, 0, 8'h55, 8'h00, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("f_err_sat", err_count, 255);
        check("f_err_idle", err_pulse, 0);
`endif

        // partial key was abandoned: a full reload from index 0
        load_from(0, 1'b0, WC);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/stream_cipher_ctrl.md
STREAM_CIPHER_CTRL -- requirements
Module: stream_cipher_ctrl

Interface
REQ-001 Parameter KEY_BYTES, default 16: key length in bytes; legal range 2..256.
REQ-002 Parameter WARMUP_CYCLES, default 8: keystream discard steps after init; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 in_byte  in  8  byte from reader.
REQ-006 in_is_key  in  1  marks in_byte as key material.
REQ-007 in_valid  in  1  in_byte valid.
REQ-008 in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-009 key_byte  out  8  byte to key storage.
REQ-010 key_we  out  1  key storage write strobe, one cycle per byte.
REQ-011 key_idx  out  $clog2(KEY_BYTES)  key storage write address.
REQ-012 ks_init  out  1  one-cycle keystream engine init pulse.
REQ-013 ks_step  out  1  advance keystream one byte.
REQ-014 ks_byte  in  8  current keystream byte, valid while engine is initialised.
REQ-015 ct_byte  out  8  ciphertext byte.
REQ-016 ct_valid, ct_ready  out, in  1 each  output valid/ready handshake.
REQ-017 key_loaded  out  1  high only in READY.
REQ-018 err_pulse  out  1, err_count  out  8  present only with CIPHER_CTRL_ERR_EN.

Function
REQ-019 FSM states: IDLE, LOAD_KEY, INIT, WARMUP, READY.
REQ-020 IDLE: in_ready=1; an accepted key byte writes key_idx=0 and goes to LOAD_KEY.
REQ-021 LOAD_KEY: in_ready=1; each accepted key byte drives key_byte=in_byte, key_we=1 and key_idx=count in the same cycle, combinationally from the input, then increments count.
REQ-022 When the write at idx KEY_BYTES-1 is accepted, go to INIT; count resets to 0.
REQ-023 INIT lasts exactly one cycle with ks_init=1 and in_ready=0, then goes to WARMUP.
REQ-024 WARMUP: in_ready=0; ks_step=1 for exactly WARMUP_CYCLES cycles, then go to READY.
REQ-025 READY: a data byte is accepted when the output register is empty, or when it is full with ct_ready=1.
REQ-026 Data byte accept: ct_byte <= in_byte ^ ks_byte, ct_valid <= 1, ks_step=1 in the same cycle; latency is one cycle.
REQ-027 ct_valid clears on ct_valid && ct_ready with no new accept; simultaneous drain and accept gives back-to-back output with no bubble.
REQ-028 Key byte accepted in READY: rekey; writes key_idx=0 and goes to LOAD_KEY, dropping key_loaded the next cycle.
REQ-029 A pending ct_byte survives rekey, INIT and WARMUP unchanged until drained.
REQ-030 Data byte offered in IDLE or LOAD_KEY: accepted and dropped; no ks_step and no output.
REQ-031 ks_step never asserts outside WARMUP and data accepts.
REQ-032 ks_init and ks_step are never high together.

Reset
REQ-033 Asynchronous nrst low: state=IDLE, count=0, ct_valid=0, ct_byte=0, key_we=0, ks_init=0, ks_step=0, key_loaded=0, err_count=0.
REQ-034 Reset mid-load or mid-warmup abandons the partial key; a full reload is required.

Configuration
REQ-035 With CIPHER_CTRL_ERR_EN defined: a data byte dropped per REQ-030 gives err_pulse=1 for that cycle, and err_count increments, saturating at 255.
REQ-036 With CIPHER_CTRL_ERR_EN undefined: err_pulse and err_count ports do not exist, and drops are silent; all other behaviour is identical.

Structure
REQ-037 Package cipher_pkg holds the state enum typedef, the default KEY_BYTES/WARMUP_CYCLES localparams, and the byte_t typedef.
REQ-038 One sub-module, cipher_out_reg: a one-entry valid/ready holding register for ct_byte; the FSM, counters and XOR live in stream_cipher_ctrl.

Verification
REQ-039 KEY_BYTES=4; key bytes 11,22,33,44 -> key_we on idx 0..3; ks_init exactly 1 cycle later; 8 ks_step cycles; then key_loaded=1.
REQ-040 READY, ks_byte=0xA5, data 0x3C, ct_ready=1 -> ct_byte=0x99 next cycle; ks_step=1 on the accept cycle.
REQ-041 READY, ct_ready=0, two data bytes -> first held, in_ready=0; raise ct_ready -> second accepted in the same cycle the first drains.
REQ-042 Data byte 0x55 in IDLE -> no ct_valid, no ks_step; with ERR_EN, err_pulse=1 and err_count=1; after 300 drops, err_count=255.
REQ-043 Key byte in READY with ct_valid=1 pending -> key_idx=0 write, key_loaded=0; pending ct_byte drained unchanged later.
REQ-044 nrst low during WARMUP cycle 3 -> state=IDLE and all outputs at reset values; ks_step stops immediately.
